// File: rtl/aes_pkg.sv
// Shared AES definitions for the key-schedule and cipher stages.
//   KEY_W / RND_W    : round-key width and round-index width (AES-128).
//   RCON[1:10]       : key-expansion round constants.
//   inv_ks_state_t   : state encoding of the inverse key-schedule FSM.
//   rcon_of()        : bounds-safe RCON lookup (returns 0 outside 1..10).
package aes_pkg;

  localparam int KEY_W = 128;
  localparam int RND_W = 4;

  localparam logic [7:0] RCON [1:10] = '{
    8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
    8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
  };

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_EXPAND = 2'd1,
    ST_EMIT   = 2'd2,
    ST_DONE   = 2'd3
  } inv_ks_state_t;

  // Round index 0 never reaches the datapath as a real constant, but the
  // counter can legitimately hold 0, so guard the array bounds here.
  function automatic logic [7:0] rcon_of(input logic [RND_W-1:0] r);
    logic [7:0] v;
    v = 8'h00;
    if ((r >= 4'd1) && (r <= 4'd10)) v = RCON[r];
    return v;
  endfunction

endpackage

// File: rtl/aes_sbox.sv
// Combinational AES forward S-box (one byte).
//   x : input byte
//   y : substituted byte
module aes_sbox (
  input  logic [7:0] x,
  output logic [7:0] y
);

  localparam logic [7:0] SBOX [0:255] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  assign y = SBOX[x];

endmodule

// File: rtl/inv_key_schedule.sv
// AES-128 round-key generator for the decryption path.
// Expands the cipher key forward to round 10, then walks the schedule
// backwards, presenting round keys 10..0 on a valid/ready port.
//   clk, reset : clock, asynchronous active-high reset
//   enable     : start request (IDLE only); inputkey captured with it
//   inputkey   : 128-bit cipher key, byte 0 in [127:120]
//   keyReady   : consumer accepts the presented round key
//   roundKey   : presented round key (registered)
//   roundNum   : index of roundKey (10..0)
//   keyValid   : roundKey/roundNum valid
//   busy       : high in every state except IDLE
//   success    : one-cycle pulse after round 0 has been accepted
//   dbg_state  : current FSM state, for observation only
//
// Handshake: a transfer happens on a rising edge where keyValid && keyReady.
// While keyValid is high and keyReady is low, roundKey/roundNum hold; keyValid
// only falls after the round-0 transfer (or on reset).
module inv_key_schedule
  import aes_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic [KEY_W-1:0]  inputkey,
  input  logic              keyReady,
  output logic [KEY_W-1:0]  roundKey,
  output logic [RND_W-1:0]  roundNum,
  output logic              keyValid,
  output logic              busy,
  output logic              success,
  output inv_ks_state_t     dbg_state
);

  inv_ks_state_t     state_q, state_d;
  logic [KEY_W-1:0]  key_q, key_d;
  // Doubles as the forward step counter r in EXPAND and roundNum in EMIT;
  // it finishes EXPAND at 10, which is exactly the first round presented.
  logic [RND_W-1:0]  rnd_q, rnd_d;

  logic [31:0] w0, w1, w2, w3, w3p;
  logic [31:0] sub_in, rot, sub_out, t;
  logic [31:0] f0, f1, f2, f3;
  logic [KEY_W-1:0] fwd_key, bwd_key;

  assign w0  = key_q[127:96];
  assign w1  = key_q[95:64];
  assign w2  = key_q[63:32];
  assign w3  = key_q[31:0];
  assign w3p = w3 ^ w2;

  // One SubWord for both directions: the backward step needs the
  // recovered w3 of the previous round, which is w3^w2.
  assign sub_in = (state_q == ST_EMIT) ? w3p : w3;
  assign rot    = {sub_in[23:0], sub_in[31:24]};

  aes_sbox u_sbox0 (.x(rot[31:24]), .y(sub_out[31:24]));
  aes_sbox u_sbox1 (.x(rot[23:16]), .y(sub_out[23:16]));
  aes_sbox u_sbox2 (.x(rot[15:8]),  .y(sub_out[15:8]));
  aes_sbox u_sbox3 (.x(rot[7:0]),   .y(sub_out[7:0]));

  assign t = sub_out ^ {rcon_of(rnd_q), 24'h000000};

  assign f0 = w0 ^ t;
  assign f1 = w1 ^ f0;
  assign f2 = w2 ^ f1;
  assign f3 = w3 ^ f2;
  assign fwd_key = {f0, f1, f2, f3};

  assign bwd_key = {w0 ^ t, w1 ^ w0, w2 ^ w1, w3p};

  always_comb begin
    state_d = state_q;
    key_d   = key_q;
    rnd_d   = rnd_q;
    case (state_q)
      ST_IDLE: begin
        if (enable) begin
          key_d   = inputkey;
          rnd_d   = 4'd1;
          state_d = ST_EXPAND;
        end
      end
      ST_EXPAND: begin
        key_d = fwd_key;
        if (rnd_q == 4'd10) state_d = ST_EMIT;
        else                rnd_d   = rnd_q + 4'd1;
      end
      ST_EMIT: begin
        if (keyReady) begin
          if (rnd_q == 4'd0) begin
            state_d = ST_DONE;
          end else begin
            key_d = bwd_key;
            rnd_d = rnd_q - 4'd1;
          end
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      key_q   <= '0;
      rnd_q   <= '0;
    end else begin
      state_q <= state_d;
      key_q   <= key_d;
      rnd_q   <= rnd_d;
    end
  end

  assign roundKey  = key_q;
  assign roundNum  = rnd_q;
  assign keyValid  = (state_q == ST_EMIT);
  assign busy      = (state_q != ST_IDLE);
  assign success   = (state_q == ST_DONE);
  assign dbg_state = state_q;

endmodule

// File: tb/tb_inv_key_schedule.sv
// Directed testbench for inv_key_schedule: FIPS-197 and all-zero keys,
// backpressure, ignored enables, mid-run reset and back-to-back starts.
module tb_inv_key_schedule;

  localparam logic [127:0] OTHER_KEY = 128'h000102030405060708090a0b0c0d0e0f;

  logic                  clk;
  logic                  reset;
  logic                  enable;
  logic [127:0]          inputkey;
  logic                  keyReady;
  logic [127:0]          roundKey;
  logic [3:0]            roundNum;
  logic                  keyValid;
  logic                  busy;
  logic                  success;
  aes_pkg::inv_ks_state_t dbg_state;

  inv_key_schedule dut (
    .clk(clk), .reset(reset), .enable(enable), .inputkey(inputkey),
    .keyReady(keyReady), .roundKey(roundKey), .roundNum(roundNum),
    .keyValid(keyValid), .busy(busy), .success(success), .dbg_state(dbg_state)
  );

  // clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got running expected finished");
    $fatal(1);
  end

  int checks = 0;
  int fails  = 0;

  // scoreboard: expected round keys, round numbers, and whether the key is known
  logic [127:0] exp_q[$];
  logic [3:0]   rn_q[$];
  logic         kn_q[$];

  logic [127:0] fips_rk [0:10];
  logic [127:0] zero_rk [0:10];
  logic [10:0]  zero_known;

  task automatic chkk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chkb(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chkn(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chkk({tag, "_roundKey"}, roundKey, 128'h0);
    chkn({tag, "_roundNum"}, int'(roundNum), 0);
    chkb({tag, "_keyValid"}, keyValid, 1'b0);
    chkb({tag, "_busy"}, busy, 1'b0);
    chkb({tag, "_success"}, success, 1'b0);
  endtask

  task automatic load_exp(input int which);
    exp_q.delete(); rn_q.delete(); kn_q.delete();
    for (int r = 10; r >= 0; r--) begin
      exp_q.push_back(which == 0 ? fips_rk[r] : zero_rk[r]);
      rn_q.push_back(4'(r));
      kn_q.push_back(which == 0 ? 1'b1 : zero_known[r]);
    end
  endtask

  // Drive enable at the current negedge; the next rising edge accepts it.
  task automatic start(input logic [127:0] key);
    enable   = 1'b1;
    inputkey = key;
  endtask

  // Waits for keyValid after the accepting edge; expects 10 cycles.
  task automatic wait_valid(input bit hold, input bit poke);
    int n;
    n = 0;
    @(negedge clk);
    if (!hold) enable = 1'b0;
    while (!keyValid && n < 40) begin
      chkb("busy_expand", busy, 1'b1);
      if (poke && n == 3) begin enable = 1'b1; inputkey = OTHER_KEY; end
      if (poke && n == 4) enable = 1'b0;
      @(negedge clk);
      n++;
    end
    chkn("latency_to_valid", n, 10);
  endtask

  // Consumes the expected queue. mode 0: keyReady high, 1: random.
  // stall: cycles of keyReady=0 first. abort_rn >= 0: reset when that round shows.
  task automatic drain(input int mode, input int stall, input bit poke,
                       input int abort_rn, output bit aborted);
    int cyc;
    bit seen;
    cyc = 0; seen = 0; aborted = 0;
    while (exp_q.size() > 0 && cyc < 300) begin
      if (cyc < stall)     keyReady = 1'b0;
      else if (mode == 0)  keyReady = 1'b1;
      else                 keyReady = 1'($urandom_range(0, 1));
      if (poke) begin
        enable = (cyc == 2);
        if (cyc == 2) inputkey = OTHER_KEY;
      end
      if (seen) chkb("keyValid_held", keyValid, 1'b1);
      chkb("no_early_success", success, 1'b0);
      chkb("busy_emit", busy, 1'b1);
      if (keyValid) begin
        seen = 1;
        if (abort_rn >= 0 && int'(roundNum) == abort_rn) begin
          reset = 1'b1;
          #1;
          chk_all_zero("async_reset");
          aborted  = 1;
          keyReady = 1'b0;
          enable   = 1'b0;
          return;
        end
        chkn("roundNum", int'(roundNum), int'(rn_q[0]));
        if (kn_q[0]) chkk($sformatf("roundKey_r%0d", rn_q[0]), roundKey, exp_q[0]);
        if (keyReady) begin
          void'(exp_q.pop_front());
          void'(rn_q.pop_front());
          void'(kn_q.pop_front());
        end
      end
      @(negedge clk);
      cyc++;
    end
    if (poke) enable = 1'b0;
    keyReady = 1'b0;
    chkn("drain_remaining", exp_q.size(), 0);
    chkb("success_pulse", success, 1'b1);
    chkb("done_keyValid", keyValid, 1'b0);
    chkb("done_busy", busy, 1'b1);
    @(negedge clk);
    chkb("success_one_cycle", success, 1'b0);
    chkb("idle_busy", busy, 1'b0);
  endtask

  bit ab;

  initial begin
    fips_rk[0]  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    fips_rk[1]  = 128'ha0fafe1788542cb123a339392a6c7605;
    fips_rk[2]  = 128'hf2c295f27a96b9435935807a7359f67f;
    fips_rk[3]  = 128'h3d80477d4716fe3e1e237e446d7a883b;
    fips_rk[4]  = 128'hef44a541a8525b7fb671253bdb0bad00;
    fips_rk[5]  = 128'hd4d1c6f87c839d87caf2b8bc11f915bc;
    fips_rk[6]  = 128'h6d88a37a110b3efddbf98641ca0093fd;
    fips_rk[7]  = 128'h4e54f70e5f5fc9f384a64fb24ea6dc4f;
    fips_rk[8]  = 128'head27321b58dbad2312bf5607f8d292f;
    fips_rk[9]  = 128'hac7766f319fadc2128d12941575c006e;
    fips_rk[10] = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    for (int r = 0; r <= 10; r++) zero_rk[r] = 128'h0;
    zero_rk[1]  = 128'h62636363626363636263636362636363;
    zero_rk[10] = 128'hb4ef5bcb3e92e21123e951cf6f8f188e;
    zero_known  = 11'b100_0000_0011;

    reset = 1'b1; enable = 1'b0; keyReady = 1'b0; inputkey = '0;
    repeat (3) @(negedge clk);
    chk_all_zero("reset");
    chkn("reset_state", int'(dbg_state), int'(aes_pkg::ST_IDLE));
    reset = 1'b0;
    @(negedge clk);

    // FIPS-197 key, consumer always ready
    load_exp(0);
    start(fips_rk[0]);
    wait_valid(0, 0);
    drain(0, 0, 0, -1, ab);

    // all-zero key
    load_exp(1);
    start(128'h0);
    wait_valid(0, 0);
    drain(0, 0, 0, -1, ab);

    // backpressure, random ready, ignored enables in EXPAND and EMIT
    load_exp(0);
    start(fips_rk[0]);
    wait_valid(0, 1);
    drain(1, 5, 1, -1, ab);

    // reset during EMIT at round 6, then a full zero-key run
    load_exp(0);
    start(fips_rk[0]);
    wait_valid(0, 0);
    drain(0, 0, 0, 6, ab);
    chkb("aborted_at_6", ab, 1'b1);
    @(negedge clk);
    @(negedge clk);
    chk_all_zero("held_reset");
    reset = 1'b0;
    @(negedge clk);
    load_exp(1);
    start(128'h0);
    wait_valid(0, 0);
    drain(0, 0, 0, -1, ab);

    // back-to-back with enable held high
    load_exp(0);
    start(fips_rk[0]);
    wait_valid(1, 0);
    drain(0, 0, 0, -1, ab);
    load_exp(0);
    wait_valid(0, 0);
    drain(0, 0, 0, -1, ab);

    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule

// File: doc/inv_key_schedule.md
# inv_key_schedule

Round-key generator for the AES-128 decryption path. It takes the 128-bit cipher key and expands it forward to the round-10 key. It then emits round keys in reverse order (10 down to 0) over a valid/ready handshake, one per accepted transfer, to the inverse-cipher AddRoundKey stage. It reports completion with a one-cycle `success` pulse, the same completion convention the encryption-side stages use.

## Interface
- No parameters; AES-128 only (Nk=4, Nr=10).
- `clk` input 1: single clock; all state on rising edge.
- `reset` input 1: asynchronous, active-high; clears all state and outputs.
- `enable` input 1: start request; sampled only in IDLE.
- `inputkey` input 128: cipher key, byte 0 in bits [127:120], FIPS-197 order; sampled on the accepted `enable` cycle.
- `keyReady` input 1: consumer accepts current round key.
- `roundKey` output 128: current round key, registered.
- `roundNum` output 4: round index of `roundKey` (10..0).
- `keyValid` output 1: `roundKey`/`roundNum` valid.
- `busy` output 1: high in every state except IDLE.
- `success` output 1: one-cycle pulse after round 0 is accepted.

## Operation
- FSM states: IDLE, EXPAND, EMIT, DONE.
- IDLE: when `enable`=1, latch `inputkey` into key register, set step counter r=1, go to EXPAND.
- EXPAND: each cycle, replace the key register with the forward expansion using RCON[r]:
  - w0'=w0^SubWord(RotWord(w3))^{RCON[r],24'h0}
  - w1'=w1^w0', w2'=w2^w1', w3'=w3^w2'
  - r++.
  - After r=10 is applied, go to EMIT with `roundNum`=10.
- EMIT: `keyValid`=1.
  - On `keyValid`&&`keyReady`, if `roundNum`=0, go to DONE.
  - Otherwise apply the backward step with RCON[roundNum]:
    - w3p=w3^w2, w2p=w2^w1, w1p=w1^w0
    - w0p=w0^SubWord(RotWord(w3p))^{RCON[roundNum],24'h0}
    - `roundNum`--.
- DONE: `success`=1 for exactly one cycle, `keyValid`=0, go to IDLE.
- RCON[1..10] = 01,02,04,08,10,20,40,80,1b,36.
- SubWord datapath is shared between the forward and backward steps. A mux selects w3 in EXPAND and w3^w2 in EMIT.
- All XORs are 128-bit and carry-free. `roundNum` never wraps below 0.

## Timing
- Reset values: `roundKey`=0, `roundNum`=0, `keyValid`=0, `busy`=0, `success`=0, FSM=IDLE.
- Latency:
  - `enable` accepted at edge 0.
  - EXPAND occupies edges 1..10.
  - `keyValid` is high after edge 10, presenting round 10.
- Throughput: one round key per cycle while `keyReady`=1. With `keyReady` held high, `success` pulses 11 cycles after `keyValid` first rises.
- Handshake:
  - `roundKey`/`roundNum` are held stable while `keyValid`=1 and `keyReady`=0.
  - `keyValid` never drops without an accepted transfer, except on reset.
- `keyReady` outside EMIT is ignored. `enable` outside IDLE is ignored, including in DONE.
- Back-to-back: `enable` in the cycle after DONE (FSM in IDLE) starts a new key with no bubble.
- Reset mid-operation, in any state: outputs clear immediately (asynchronously) and the in-flight key is discarded.

## Structure
- Shared package `aes_pkg`:
  - `RCON` constant array [1:10].
  - FSM state enum `inv_ks_state_t`.
  - Width constants KEY_W=128, RND_W=4.
- Sub-module `aes_sbox`: combinational 8-bit forward S-box lookup, instantiated 4 times for SubWord. It is shared with the encryption-side SubBytes owners.
- Forward/backward step logic stays inline in `inv_key_schedule`.

## Test plan
- FIPS-197 key 2b7e151628aed2a6abf7158809cf4f3c, `keyReady`=1:
  - First transfer: round 10 = d014f9a8c9ee2589e13f0cc8b6630ca6.
  - Next: round 9 = ac7766f319fadc2128d12941575c006e.
  - Second-to-last: round 1 = a0fafe1788542cb123a339392a6c7605.
  - Last: round 0 = 2b7e151628aed2a6abf7158809cf4f3c.
  - `success` pulses one cycle after round 0 is accepted.
- All-zero key:
  - Round 10 = b4ef5bcb3e92e21123e951cf6f8f188e.
  - Round 1 = 62636363626363636263636362636363.
  - Round 0 = all zeros.
- Backpressure: hold `keyReady`=0 for 5 cycles while round 10 is presented -> `roundKey`/`roundNum` are unchanged every cycle and no key is dropped or duplicated. Randomly toggle `keyReady` for the rest of the run -> the 11 keys arrive in order.
- `enable` pulsed with a different key during EXPAND and EMIT -> ignored; the sequence matches the first key, and `busy` stays 1 until DONE.
- `reset` asserted mid-EMIT (`roundNum`=6) -> all outputs are 0 in the same cycle. After release, a new `enable` produces the full correct sequence.
- Back-to-back: `enable` held high continuously -> the second expansion starts the cycle after DONE, and `keyValid` rises 10 cycles later.
